div_seq_param: RTL and testbench

Parametrised multicycle restoring divider for the CPU's DIV/DIVU instructions; successor to the fixed 32-bit unsigned divider. Adds a WIDTH parameter, signed mode, a busy flag, a registered divide-by-zero flag with an early exit, and a synchronous abort. The control unit starts it with a one-cycle pulse and waits for DIV_END, then writes HI (remainder) and LO (quotient).

---
 rtl/div_seq_param_if.sv | 27 ++
 rtl/div_seq_param.sv | 126 ++++++++++++
 tb/tb_div_seq_param.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/div_seq_param_if.sv
// Handshake and data bundle between the control unit and the sequential divider.
interface div_seq_param_if #(
    parameter int WIDTH = 32
);
    logic             DIV_START;
    logic             DIV_SIGNED;
    logic             DIV_ABORT;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             DIV_BUSY;
    logic             DIV_END;
    logic             DIV_O;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    // Control unit side: issues operations, consumes results.
    modport master (
        output DIV_START, DIV_SIGNED, DIV_ABORT, A, B,
        input  DIV_BUSY, DIV_END, DIV_O, HI, LO
    );

    // Divider side.
    modport slave (
        input  DIV_START, DIV_SIGNED, DIV_ABORT, A, B,
        output DIV_BUSY, DIV_END, DIV_O, HI, LO
    );
endinterface

// File: rtl/div_seq_param.sv
// Multicycle restoring divider (signed/unsigned) with divide-by-zero early exit
// and synchronous abort. HI = remainder, LO = quotient, all outputs registered.
module div_seq_param #(
    parameter int WIDTH = 32
) (
    input logic            clock,
    input logic            reset,
    div_seq_param_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIXUP, DONE} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] rem, quo, divisor;
    logic [CW-1:0]    cnt;
    logic             sign_q, sign_r, div_zero;
    logic             busy, end_p, dz_flag;
    logic [WIDTH-1:0] hi_r, lo_r;
    logic             accept, abort_now;
    logic [WIDTH-1:0] mag_a, mag_b, shifted;
    logic [WIDTH:0]   trial;

    // Operand magnitudes and the trial subtract for one restoring step.
    // quo doubles as the dividend shift register, so its MSB feeds the remainder.
    always_comb begin
        mag_a   = (bus.DIV_SIGNED && bus.A[WIDTH-1]) ? -bus.A : bus.A;
        mag_b   = (bus.DIV_SIGNED && bus.B[WIDTH-1]) ? -bus.B : bus.B;
        shifted = {rem[WIDTH-2:0], quo[WIDTH-1]};
        trial   = {1'b0, shifted} - {1'b0, divisor};
    end

    // Abort only matters while an operation is in flight.
    assign abort_now = bus.DIV_ABORT && (state == RUN || state == FIXUP);

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state logic. A zero divisor skips RUN and goes straight to FIXUP,
    // which then publishes the divide-by-zero result one edge after the start.
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.DIV_START) begin
                    accept  = 1'b1;
                    state_n = (bus.B == '0) ? FIXUP : RUN;
                end
            end
            RUN: begin
                if (abort_now)      state_n = IDLE;
                else if (cnt == '0) state_n = FIXUP;
            end
            FIXUP: begin
                if (abort_now) state_n = IDLE;
                else           state_n = DONE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Datapath: operand latch, one restoring step per RUN cycle while the
    // counter is non-zero, sign fix-up and result registration in FIXUP.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rem      <= '0;
            quo      <= '0;
            divisor  <= '0;
            cnt      <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            div_zero <= 1'b0;
            busy     <= 1'b0;
            end_p    <= 1'b0;
            dz_flag  <= 1'b0;
            hi_r     <= '0;
            lo_r     <= '0;
        end else begin
            end_p <= 1'b0;
            if (accept) begin
                busy     <= 1'b1;
                dz_flag  <= 1'b0;
                div_zero <= (bus.B == '0);
                // On divide-by-zero the raw dividend is kept for HI.
                quo      <= (bus.B == '0) ? bus.A : mag_a;
                divisor  <= mag_b;
                rem      <= '0;
                cnt      <= CW'(WIDTH);
                sign_q   <= bus.DIV_SIGNED & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                sign_r   <= bus.DIV_SIGNED & bus.A[WIDTH-1];
            end else if (abort_now) begin
                busy <= 1'b0;
            end else if (state == RUN && cnt != '0) begin
                cnt <= cnt - CW'(1);
                if (!trial[WIDTH]) begin
                    rem <= trial[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], 1'b1};
                end else begin
                    rem <= shifted;
                    quo <= {quo[WIDTH-2:0], 1'b0};
                end
            end else if (state == FIXUP) begin
                busy  <= 1'b0;
                end_p <= 1'b1;
                if (div_zero) begin
                    dz_flag <= 1'b1;
                    hi_r    <= quo;
                    lo_r    <= '1;
                end else begin
                    lo_r <= sign_q ? -quo : quo;
                    hi_r <= sign_r ? -rem : rem;
                end
            end
        end
    end

    assign bus.DIV_BUSY = busy;
    assign bus.DIV_END  = end_p;
    assign bus.DIV_O    = dz_flag;
    assign bus.HI       = hi_r;
    assign bus.LO       = lo_r;
endmodule

// File: tb/tb_div_seq_param.sv
// Randomised and directed bench for div_seq_param at WIDTH=32 and WIDTH=8,
// checked against a plain-arithmetic reference model.
module tb_div_seq_param;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    div_seq_param_if #(.WIDTH(32)) i32 ();
    div_seq_param_if #(.WIDTH(8))  i8  ();

    div_seq_param #(.WIDTH(32)) dut32 (.clock(clock), .reset(reset), .bus(i32));
    div_seq_param #(.WIDTH(8))  dut8  (.clock(clock), .reset(reset), .bus(i8));

    always #5 clock = ~clock;

    // Results of the last do_op.
    int          r_end, r_nend, r_nbusy;
    logic        r_ostart, r_busy_ab, r_o;
    logic [31:0] r_hi, r_lo;

    // Reference: truncating division on sign-extended integers; x/0 gives all-ones, rem=x.
    function automatic void ref_div(input int w, input bit sgn, input logic [31:0] a, b,
                                    output logic [31:0] q, output logic [31:0] r);
        longint mask, sa, sb;
        mask = (64'sd1 <<< w) - 1;
        if (b == 0) begin
            q = 32'(mask);
            r = a;
            return;
        end
        sa = longint'(a);
        sb = longint'(b);
        if (sgn && a[w-1]) sa = sa - (64'sd1 <<< w);
        if (sgn && b[w-1]) sb = sb - (64'sd1 <<< w);
        q = 32'((sa / sb) & mask);
        r = 32'((sa % sb) & mask);
    endfunction

    task automatic drive(input bit w8, input bit st, input bit sg, input bit ab,
                         input logic [31:0] a, input logic [31:0] b);
        if (w8) begin
            i8.DIV_START = st; i8.DIV_SIGNED = sg; i8.DIV_ABORT = ab;
            i8.A = a[7:0]; i8.B = b[7:0];
        end else begin
            i32.DIV_START = st; i32.DIV_SIGNED = sg; i32.DIV_ABORT = ab;
            i32.A = a; i32.B = b;
        end
    endtask

    task automatic sample(input bit w8, output logic e, output logic bz, output logic o,
                          output logic [31:0] hi, output logic [31:0] lo);
        if (w8) begin
            e = i8.DIV_END; bz = i8.DIV_BUSY; o = i8.DIV_O;
            hi = {24'd0, i8.HI}; lo = {24'd0, i8.LO};
        end else begin
            e = i32.DIV_END; bz = i32.DIV_BUSY; o = i32.DIV_O;
            hi = i32.HI; lo = i32.LO;
        end
    endtask

    // Start one operation (edge 0) and watch a fixed window. ie: edge of an extra
    // start with junk operands; ae: edge of DIV_ABORT (0 = with the start, -1 = none).
    task automatic do_op(input bit w8, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         input int ie, input int ae);
        int          n;
        logic        e, bz, o;
        logic [31:0] hi, lo;
        n = w8 ? 14 : 38;
        r_end = -1; r_nend = 0; r_nbusy = 0; r_ostart = 1'bx; r_busy_ab = 1'bx;
        @(negedge clock);
        drive(w8, 1'b1, sgn, ae == 0, a, b);
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            sample(w8, e, bz, o, hi, lo);
            if (k == 0) r_ostart = o;
            if (k == ae) r_busy_ab = bz;
            if (bz) r_nbusy++;
            if (e) begin
                r_nend++;
                if (r_end < 0) begin r_end = k; r_hi = hi; r_lo = lo; r_o = o; end
            end
            drive(w8, (k + 1 == ie), ~sgn, (k + 1 == ae), 32'h55, 32'h3);
        end
        if (r_end < 0) begin r_hi = hi; r_lo = lo; r_o = o; end
        drive(w8, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        #2;
        n_chk++; if (i32.DIV_BUSY !== 1'b0 || i32.DIV_END !== 1'b0 || i32.DIV_O !== 1'b0) begin n_fail++; $display("FAIL reset_flags32: got busy=%b end=%b o=%b expected 0 0 0", i32.DIV_BUSY, i32.DIV_END, i32.DIV_O); end
        n_chk++; if (i32.HI !== 32'h0 || i32.LO !== 32'h0) begin n_fail++; $display("FAIL reset_data32: got hi=%h lo=%h expected 0 0", i32.HI, i32.LO); end
        n_chk++; if (i8.DIV_BUSY !== 1'b0 || i8.HI !== 8'h0 || i8.LO !== 8'h0) begin n_fail++; $display("FAIL reset8: got busy=%b hi=%h lo=%h expected 0 0 0", i8.DIV_BUSY, i8.HI, i8.LO); end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_unsigned_basic();
        do_op(1'b0, 1'b0, 32'd7, 32'd2, -1, -1);
        n_chk++; if (r_end !== 34) begin n_fail++; $display("FAIL u_latency: got %0d expected 34", r_end); end
        n_chk++; if (r_nend !== 1) begin n_fail++; $display("FAIL u_end_count: got %0d expected 1", r_nend); end
        n_chk++; if (r_lo !== 32'd3 || r_hi !== 32'd1 || r_o !== 1'b0) begin n_fail++; $display("FAIL u_result: got lo=%h hi=%h o=%b expected 3 1 0", r_lo, r_hi, r_o); end
        n_chk++; if (r_nbusy !== 34) begin n_fail++; $display("FAIL u_busy_cycles: got %0d expected 34", r_nbusy); end
    endtask

    task automatic test_signed();
        do_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, -1, -1);
        n_chk++; if (r_lo !== 32'hFFFF_FFFD || r_hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL s_neg7_div2: got lo=%h hi=%h expected fffffffd ffffffff", r_lo, r_hi); end
        do_op(1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2, -1, -1);
        n_chk++; if (r_lo !== 32'h7FFF_FFFC || r_hi !== 32'd1) begin n_fail++; $display("FAIL u_big_div2: got lo=%h hi=%h expected 7ffffffc 1", r_lo, r_hi); end
        do_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
        n_chk++; if (r_lo !== 32'h8000_0000 || r_hi !== 32'h0 || r_o !== 1'b0) begin n_fail++; $display("FAIL s_overflow: got lo=%h hi=%h o=%b expected 80000000 0 0", r_lo, r_hi, r_o); end
    endtask

    task automatic test_div_zero();
        do_op(1'b0, 1'b0, 32'h1234_5678, 32'd0, -1, -1);
        n_chk++; if (r_end !== 1 || r_nend !== 1) begin n_fail++; $display("FAIL dz_latency: got end=%0d count=%0d expected 1 1", r_end, r_nend); end
        n_chk++; if (r_o !== 1'b1 || r_hi !== 32'h1234_5678 || r_lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dz_result: got o=%b hi=%h lo=%h expected 1 12345678 ffffffff", r_o, r_hi, r_lo); end
        n_chk++; if (r_nbusy !== 1) begin n_fail++; $display("FAIL dz_busy_cycles: got %0d expected 1", r_nbusy); end
        do_op(1'b0, 1'b0, 32'd10, 32'd3, -1, -1);
        n_chk++; if (r_ostart !== 1'b0) begin n_fail++; $display("FAIL dz_clear_at_start: got %b expected 0", r_ostart); end
        n_chk++; if (r_lo !== 32'd3 || r_hi !== 32'd1 || r_o !== 1'b0) begin n_fail++; $display("FAIL after_dz: got lo=%h hi=%h o=%b expected 3 1 0", r_lo, r_hi, r_o); end
    endtask

    task automatic test_abort();
        logic [31:0] hi0, lo0;
        // Extra start at edge 5 must not disturb 100/7.
        do_op(1'b0, 1'b0, 32'd100, 32'd7, 5, -1);
        n_chk++; if (r_end !== 34 || r_nend !== 1 || r_lo !== 32'd14 || r_hi !== 32'd2) begin n_fail++; $display("FAIL ignored_start: got end=%0d n=%0d lo=%h hi=%h expected 34 1 e 2", r_end, r_nend, r_lo, r_hi); end
        hi0 = r_hi; lo0 = r_lo;
        do_op(1'b0, 1'b0, 32'd100, 32'd7, 5, 10);
        n_chk++; if (r_busy_ab !== 1'b0 || r_nend !== 0) begin n_fail++; $display("FAIL abort: got busy=%b ends=%0d expected 0 0", r_busy_ab, r_nend); end
        n_chk++; if (r_hi !== hi0 || r_lo !== lo0 || r_o !== 1'b0) begin n_fail++; $display("FAIL abort_hold: got hi=%h lo=%h o=%b expected %h %h 0", r_hi, r_lo, r_o, hi0, lo0); end
        n_chk++; if (r_nbusy !== 10) begin n_fail++; $display("FAIL abort_busy_cycles: got %0d expected 10", r_nbusy); end
        // Abort and start together while busy: abort wins, nothing restarts.
        do_op(1'b0, 1'b0, 32'd100, 32'd7, 10, 10);
        n_chk++; if (r_nend !== 0 || r_nbusy !== 10) begin n_fail++; $display("FAIL abort_priority: got ends=%0d busy=%0d expected 0 10", r_nend, r_nbusy); end
        // Abort while idle is ignored.
        do_op(1'b1, 1'b0, 32'd200, 32'd7, -1, 0);
        n_chk++; if (r_end !== 10 || r_lo !== 32'd28 || r_hi !== 32'd4) begin n_fail++; $display("FAIL idle_abort: got end=%0d lo=%h hi=%h expected 10 1c 4", r_end, r_lo, r_hi); end
    endtask

    task automatic test_reset_mid_op();
        @(negedge clock);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd100, 32'd7);
        @(posedge clock);
        #1 drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (10) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        n_chk++; if (i32.DIV_BUSY !== 1'b0 || i32.DIV_END !== 1'b0 || i32.DIV_O !== 1'b0 || i32.HI !== 32'h0 || i32.LO !== 32'h0) begin n_fail++; $display("FAIL async_reset: got busy=%b end=%b o=%b hi=%h lo=%h expected all 0", i32.DIV_BUSY, i32.DIV_END, i32.DIV_O, i32.HI, i32.LO); end
        n_chk++; if (i8.HI !== 8'h0 || i8.LO !== 8'h0) begin n_fail++; $display("FAIL async_reset8: got hi=%h lo=%h expected 0 0", i8.HI, i8.LO); end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_width8();
        do_op(1'b1, 1'b0, 32'd200, 32'd7, -1, -1);
        n_chk++; if (r_end !== 10 || r_lo !== 32'd28 || r_hi !== 32'd4) begin n_fail++; $display("FAIL w8_unsigned: got end=%0d lo=%h hi=%h expected 10 1c 4", r_end, r_lo, r_hi); end
        do_op(1'b1, 1'b1, 32'h80, 32'd3, -1, -1);
        n_chk++; if (r_lo !== 32'hD6 || r_hi !== 32'hFE) begin n_fail++; $display("FAIL w8_signed: got lo=%h hi=%h expected d6 fe", r_lo, r_hi); end
    endtask

    task automatic test_random();
        logic [31:0] a, b, q, r, mask;
        bit          w8, sgn;
        int          w;
        for (int i = 0; i < 40; i++) begin
            w8   = (i % 2) == 1;
            w    = w8 ? 8 : 32;
            mask = w8 ? 32'hFF : 32'hFFFF_FFFF;
            sgn  = 1'($urandom_range(0, 1));
            a    = $urandom;
            b    = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: b = 32'hFFFF_FFFF;
                2: b = $urandom_range(1, 9);
                3: a = w8 ? 32'h80 : 32'h8000_0000;
                default: ;
            endcase
            a = a & mask;
            b = b & mask;
            ref_div(w, sgn, a, b, q, r);
            do_op(w8, sgn, a, b, -1, -1);
            n_chk++; if (r_lo !== q || r_hi !== r) begin n_fail++; $display("FAIL rand_%0d w=%0d s=%0d a=%h b=%h: got lo=%h hi=%h expected %h %h", i, w, sgn, a, b, r_lo, r_hi, q, r); end
            n_chk++; if (r_o !== (b == 0) || r_end !== ((b == 0) ? 1 : w + 2) || r_nend !== 1) begin n_fail++; $display("FAIL rand_ctl_%0d: got o=%b end=%0d n=%0d expected %b %0d 1", i, r_o, r_end, r_nend, b == 0, (b == 0) ? 1 : w + 2); end
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        test_reset();
        test_unsigned_basic();
        test_signed();
        test_div_zero();
        test_abort();
        test_reset_mid_op();
        test_width8();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
